// File: rtl/multicycle_core.sv
// Multicycle MIPS-subset core (add/sub/and/or/slt, lw, sw, beq, addi, j) sharing
// a single request/ready memory port; one instruction in flight at a time.
module multicycle_core #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned ADDR_W          = 32,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic              retire,
    output logic              halted
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC,
        ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, HALT
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_run;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_mdr;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_alu;
    logic [31:0] r_rf [32];

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [31:0] w_imm;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic        w_legal;
    logic [31:0] w_alu_res;
    logic        w_rf_we;
    logic [4:0]  w_rf_waddr;
    logic [31:0] w_rf_wdata;
    logic [31:0] w_byte_addr;

    assign w_op     = r_ir[31:26];
    assign w_funct  = r_ir[5:0];
    assign w_rs     = r_ir[25:21];
    assign w_rt     = r_ir[20:16];
    assign w_rd     = r_ir[15:11];
    assign w_imm    = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_rs_val = (w_rs == 5'd0) ? '0 : r_rf[w_rs];
    assign w_rt_val = (w_rt == 5'd0) ? '0 : r_rf[w_rt];

    always_comb begin
        w_legal = 1'b0;
        case (w_op)
            OP_RTYPE: w_legal = (w_funct == F_ADD) || (w_funct == F_SUB) || (w_funct == F_AND)
                             || (w_funct == F_OR) || (w_funct == F_SLT);
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: w_legal = 1'b1;
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (w_funct)
            F_ADD:   w_alu_res = r_a + r_b;
            F_SUB:   w_alu_res = r_a - r_b;
            F_AND:   w_alu_res = r_a & r_b;
            F_OR:    w_alu_res = r_a | r_b;
            F_SLT:   w_alu_res = {31'b0, $signed(r_a) < $signed(r_b)};
            default: w_alu_res = '0;
        endcase
    end

    // r_run keeps the fetch request low for the first cycle after reset release.
    always_comb begin
        w_next     = r_state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        retire     = 1'b0;
        halted     = 1'b0;
        w_rf_we    = 1'b0;
        w_rf_waddr = w_rt;
        w_rf_wdata = r_alu;
        case (r_state)
            FETCH: begin
                mem_req = r_run;
                if (r_run && mem_ready) w_next = DECODE;
            end
            DECODE: begin
                if (!w_legal) begin
                    if (HALT_ON_ILLEGAL) begin
                        w_next = HALT;
                    end else begin
                        w_next = FETCH;
                        retire = 1'b1;
                    end
                end else begin
                    case (w_op)
                        OP_LW, OP_SW: w_next = MEMADR;
                        OP_RTYPE:     w_next = EXEC;
                        OP_BEQ:       w_next = BRANCH;
                        OP_ADDI:      w_next = ADDIEX;
                        default:      w_next = JUMP;
                    endcase
                end
            end
            MEMADR: w_next = (w_op == OP_SW) ? MEMWR : MEMRD;
            MEMRD: begin
                mem_req = 1'b1;
                if (mem_ready) w_next = MEMWB;
            end
            MEMWB: begin
                w_rf_we    = 1'b1;
                w_rf_wdata = r_mdr;
                retire     = 1'b1;
                w_next     = FETCH;
            end
            MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) begin
                    retire = 1'b1;
                    w_next = FETCH;
                end
            end
            EXEC: w_next = ALUWB;
            ALUWB: begin
                w_rf_we    = 1'b1;
                w_rf_waddr = w_rd;
                retire     = 1'b1;
                w_next     = FETCH;
            end
            ADDIEX: w_next = ADDIWB;
            ADDIWB: begin
                w_rf_we = 1'b1;
                retire  = 1'b1;
                w_next  = FETCH;
            end
            BRANCH, JUMP: begin
                retire = 1'b1;
                w_next = FETCH;
            end
            HALT:    halted = 1'b1;
            default: w_next = FETCH;
        endcase
    end

    assign w_byte_addr = (r_state == FETCH) ? r_pc : r_alu;
    assign mem_addr    = w_byte_addr[ADDR_W-1:0];
    assign mem_wdata   = r_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
            r_run   <= 1'b0;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            r_mdr   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_alu   <= '0;
        end else begin
            r_state <= w_next;
            r_run   <= 1'b1;
            case (r_state)
                FETCH: begin
                    if (r_run && mem_ready) begin
                        r_ir <= mem_rdata;
                        r_pc <= r_pc + 32'd4;
                    end
                end
                DECODE: begin
                    r_a   <= w_rs_val;
                    r_b   <= w_rt_val;
                    r_alu <= r_pc + {w_imm[29:0], 2'b00};
                end
                MEMADR, ADDIEX: r_alu <= r_a + w_imm;
                MEMRD: begin
                    if (mem_ready) r_mdr <= mem_rdata;
                end
                EXEC: r_alu <= w_alu_res;
                BRANCH: begin
                    if (r_a == r_b) r_pc <= r_alu;
                end
                JUMP: r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
                default: ;
            endcase
        end
    end

    // Register file is deliberately not reset; r0 is forced to zero on read.
    always_ff @(posedge clk) begin
        if (w_rf_we && (w_rf_waddr != 5'd0)) r_rf[w_rf_waddr] <= w_rf_wdata;
    end

endmodule

// File: doc/multicycle_core.md
MULTICYCLE_CORE -- requirements
Module: multicycle_core

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset.
REQ-002 Parameter ADDR_W, default 32, meaning width of the memory address bus; the low ADDR_W bits of the byte address are driven.
REQ-003 Parameter HALT_ON_ILLEGAL, default 1: 1 means halt on an unsupported opcode/funct; 0 means treat it as a NOP.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 mem_req  output  1  memory access request; held high until accepted.
REQ-007 mem_we  output  1  1 = write, 0 = read; valid while mem_req is high.
REQ-008 mem_addr  output  ADDR_W  byte address; valid while mem_req is high.
REQ-009 mem_wdata  output  32  store data; valid while mem_req and mem_we are high.
REQ-010 mem_ready  input  1  access accepted and completed this cycle; read data is valid when mem_we is 0.
REQ-011 mem_rdata  input  32  read data; sampled only when mem_req, !mem_we and mem_ready are all high.
REQ-012 retire  output  1  one-cycle pulse when an instruction completes.
REQ-013 halted  output  1  core stopped after an illegal instruction; sticky until reset.

Function
REQ-014 Supported instructions: R-type add/sub/and/or/slt (funct 20/22/24/25/2A hex), lw (23), sw (2B), beq (04), addi (08), j (02).
REQ-015 Internal state: PC, IR, MDR, A, B and ALUOut registers (all 32-bit), and a 32x32 register file with r0 reading as 0 and writes to r0 ignored.
REQ-016 FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, HALT.
REQ-017 FETCH: mem_req=1, mem_we=0, mem_addr=PC; stay in FETCH until mem_ready; on mem_ready, IR<=mem_rdata, PC<=PC+4, go to DECODE.
REQ-018 DECODE: A<=rf[rs], B<=rf[rt], ALUOut<=PC+(sext(imm)<<2); next state is selected by opcode.
REQ-019 lw path: MEMADR (ALUOut<=A+sext(imm)) -> MEMRD (read at ALUOut, wait for mem_ready, MDR<=mem_rdata) -> MEMWB (rf[rt]<=MDR) -> FETCH.
REQ-020 sw path: MEMADR -> MEMWR (write B to ALUOut, wait for mem_ready) -> FETCH.
REQ-021 R-type path: EXEC (ALUOut<=A op B) -> ALUWB (rf[rd]<=ALUOut) -> FETCH.
REQ-022 addi path: ADDIEX (ALUOut<=A+sext(imm)) -> ADDIWB (rf[rt]<=ALUOut) -> FETCH.
REQ-023 beq: BRANCH sets PC<=ALUOut if A==B, else PC is unchanged -> FETCH.
REQ-024 j: JUMP sets PC<={PC[31:28], IR[25:0], 2'b00} -> FETCH.
REQ-025 Arithmetic is 32-bit modulo with overflow ignored; slt is a signed compare producing 1 or 0.
REQ-026 Latency with mem_ready tied high: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-027 mem_addr, mem_we and mem_wdata SHALL stay stable while mem_req is high and mem_ready is low.
REQ-028 mem_req is low in every state other than FETCH, MEMRD and MEMWR.
REQ-029 retire pulses in the cycle the FSM leaves MEMWB, MEMWR (on mem_ready), ALUWB, ADDIWB, BRANCH or JUMP.
REQ-030 Illegal opcode/funct with HALT_ON_ILLEGAL=1: DECODE -> HALT; HALT is absorbing with mem_req=0 and halted=1.
REQ-031 Illegal opcode/funct with HALT_ON_ILLEGAL=0: DECODE -> FETCH, with retire pulsed.
REQ-032 mem_addr is the low ADDR_W bits of the 32-bit byte address; misaligned addresses are passed through unchanged.

Reset
REQ-033 While rst_n=0: PC=RESET_PC, state=FETCH, IR/MDR/A/B/ALUOut=0, mem_req=0, retire=0, halted=0.
REQ-034 Register file contents are not reset, except that r0 always reads 0.
REQ-035 Reset asserted mid-access aborts the access immediately; after release, the first request is a fetch at RESET_PC.
REQ-036 mem_req SHALL be 0 in the cycle rst_n rises and SHALL rise on the following clock edge.

Verification
REQ-037 addi r1,r0,5; addi r2,r0,7; add r3,r1,r2; sw r3,0x40(r0) with ready tied high -> write at addr 0x40, data 12; 4 retire pulses.
REQ-038 lw r4,0x40(r0) with mem_ready delayed 3 cycles on each access -> address held stable, r4=12, instruction takes 11 cycles.
REQ-039 beq r1,r1,-1 at PC 0x10 -> next fetch at 0x10; beq r1,r2 not taken -> next fetch at 0x14.
REQ-040 j 0x0000040 at PC 0x0 -> next fetch at 0x100; slt r5,r2,r1 with r2=-1, r1=5 -> r5=1.
REQ-041 Opcode 3F with HALT_ON_ILLEGAL=1 -> halted=1, no further mem_req; rst_n pulse -> halted=0, fetch at RESET_PC.
REQ-042 rst_n dropped during a MEMWR wait -> mem_req falls asynchronously, no write is accepted, restart at RESET_PC.
